// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the program-ROM access arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner select between CPU and AUX requests.
// ROM_ARB_RR_EN selects round-robin; otherwise AUX has fixed priority.
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   aux_req_i,
`ifdef ROM_ARB_RR_EN
  input  owner_e last_i,
`endif
  output logic   grant_c_o,
  output owner_e winner_c_o
);

  always_comb begin
    grant_c_o  = cpu_req_i | aux_req_i;
    winner_c_o = OWN_CPU;
`ifdef ROM_ARB_RR_EN
    // On a tie the side not granted most recently wins
    if (cpu_req_i && aux_req_i) begin
      winner_c_o = (last_i == OWN_CPU) ? OWN_AUX : OWN_CPU;
    end else if (aux_req_i) begin
      winner_c_o = OWN_AUX;
    end
`else
    if (aux_req_i) begin
      winner_c_o = OWN_AUX;
    end
`endif
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read program ROM between CPU fetch and AUX ports.
// Define ROM_ARB_RR_EN for round-robin arbitration instead of AUX priority.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_valid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  // Counter holds ROM_LATENCY-1, so two bits cover the legal range 1..4
  localparam int unsigned CNT_W = 2;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;
  logic                cpu_valid_q, cpu_valid_d;
  logic                aux_valid_q, aux_valid_d;
  logic                busy_q, busy_d;
  logic                grant_c;
  owner_e              winner_c;

`ifdef ROM_ARB_RR_EN
  owner_e              last_q, last_d;
`endif

  rom_arb_pick u_pick (
    .cpu_req_i  (cpu_req),
    .aux_req_i  (aux_req),
`ifdef ROM_ARB_RR_EN
    .last_i     (last_q),
`endif
    .grant_c_o  (grant_c),
    .winner_c_o (winner_c)
  );

  // State, counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      cpu_valid_q <= 1'b0;
      aux_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_q      <= OWN_CPU;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      cpu_valid_q <= cpu_valid_d;
      aux_valid_q <= aux_valid_d;
      busy_q      <= busy_d;
`ifdef ROM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    cpu_valid_d = 1'b0;
    aux_valid_d = 1'b0;
`ifdef ROM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          owner_d    = winner_c;
          rom_addr_d = (winner_c == OWN_AUX) ? aux_addr : cpu_addr;
          state_d    = ST_ISSUE;
`ifdef ROM_ARB_RR_EN
          last_d     = winner_c;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(ROM_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_AUX) begin
            aux_rdata_d = rom_q;
            aux_valid_d = 1'b1;
          end else begin
            cpu_rdata_d = rom_q;
            cpu_valid_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rom_addr  = rom_addr_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign cpu_valid = cpu_valid_q;
  assign aux_valid = aux_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares one synchronous-read 32K x 8 program ROM between two requesters:
  - CPU fetch port (Z80 side).
  - AUX port (boot/copy engine or debug reader).
- Sole driver of the ROM address bus.
- Sequences each access through the ROM's registered read latency and returns data to the granted requester with a one-cycle valid strobe.
- Sits between the bus decode logic and the ROM instance.

Parameters:
- ADDR_W, 15, ROM address width.
- DATA_W, 8, ROM data width.
- ROM_LATENCY, 1, clock edges from rom_addr stable to rom_q valid; legal range 1..4.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU read request; held with cpu_addr stable until cpu_valid.
- cpu_addr  in  ADDR_W  CPU read address.
- cpu_valid  out  1  one-cycle strobe; cpu_rdata valid in this cycle.
- cpu_rdata  out  DATA_W  CPU read data; holds its value until the next CPU completion.
- aux_req  in  1  AUX read request; same rules as cpu_req.
- aux_addr  in  ADDR_W  AUX read address.
- aux_valid  out  1  one-cycle strobe for AUX.
- aux_rdata  out  DATA_W  AUX read data; holds until the next AUX completion.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_q  in  DATA_W  ROM data output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (held while reset=1):
  - State IDLE.
  - rom_addr=0, cpu_rdata=0, aux_rdata=0.
  - cpu_valid=0, aux_valid=0, busy=0.
  - Latency counter=0, round-robin pointer=CPU.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples cpu_req and aux_req at each edge.
  - If either is high: choose winner, rom_addr <= winner's address, latch owner id, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - One cycle in which the ROM captures rom_addr.
  - Load counter = ROM_LATENCY-1, go to WAIT.
- WAIT:
  - If counter==0: capture rom_q into the owner's rdata, assert the owner's valid, go to DONE.
  - Else decrement the counter.
- DONE:
  - valid is high for exactly this cycle.
  - Requests are ignored; the requester updates or drops req at the edge ending this cycle.
  - Go to IDLE.
- Latency and throughput:
  - ROM_LATENCY=1: request sampled at edge E1; valid high in the cycle after E3.
  - Minimum spacing between completions is ROM_LATENCY+3 cycles.
- Arbitration (default): fixed priority, AUX wins on simultaneous requests; the CPU waits while AUX holds req.
- Requests arriving during ISSUE, WAIT or DONE are not lost. A requester holds req, so the request is sampled on the next IDLE edge.
- rom_addr is stable from the IDLE->ISSUE edge until the next grant. It does not change between accesses.
- The non-owner's rdata and valid are never disturbed.
- The owner's address is sampled only at grant. Address changes during an access do not affect the data returned.
- Reset mid-access aborts the access: no valid is issued and the captured data is discarded.
- Data is passed through unmodified. There is no range check; all 2^ADDR_W addresses are legal.
- cpu_valid and aux_valid are never high in the same cycle.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the requester not granted most recently wins.
  - The pointer updates on every grant.
- Undefined: fixed AUX-over-CPU priority as above; the pointer register is absent.

Decomposition:
- Package rom_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum (IDLE, ISSUE, WAIT, DONE).
  - Owner id encoding: OWN_CPU=0, OWN_AUX=1.
- One sub-module, rom_arb_pick:
  - Combinational winner select from cpu_req, aux_req and the round-robin pointer.
  - Holds the ROM_ARB_RR_EN variant.
  - FSM, counter and data capture stay in the top level.

Test Plan:
- ROM model returns the low byte of the address. CPU req at addr 0x0012, ROM_LATENCY=1 -> cpu_valid high for one cycle, 3 cycles after sample, cpu_rdata=0x12; aux_valid stays 0.
- cpu_req and aux_req both asserted in the same cycle (addr 0x0005, 0x0007), fixed priority:
  - AUX completes first with 0x07.
  - CPU completes with 0x05 exactly ROM_LATENCY+3 cycles later.
  - busy returns to 0 after.
- With ROM_ARB_RR_EN, both requesting continuously -> grants alternate. With the pointer at reset=CPU the order is AUX, CPU, AUX, CPU; never two consecutive grants to one side.
- ROM_LATENCY=3, CPU read 0x7FFF -> valid 5 cycles after sample, data=0xFF; rom_addr=0x7FFF held afterwards.
- Reset asserted while in WAIT -> no valid pulse; all outputs read 0 the cycle after; a request re-presented after reset completes normally.
- CPU changes cpu_addr from 0x0010 to 0x0020 during WAIT -> returned data=0x10.
